pic_arbiter: RTL and testbench
==============================

Name: pic_arbiter

Overview:
- Programmable interrupt controller that merges NSRC external interrupt sources onto the single intr/inta handshake of pipelined_cpu_exc_int.
- Latches source edges, applies enable masking, fixed priority and in-service nesting, then presents a vector address to the CPU on acknowledge.
- Sits beside the CPU. Its register port is driven by the memory-mapped I/O decode.

Parameters:
- NSRC, 8, number of interrupt sources (2..32); index 0 has the highest priority.
- VSTRIDE, 4, byte spacing between consecutive vectors.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- irq  in  NSRC  source request lines, level inputs synchronous to clk; a rising edge raises a request.
- we  in  1  register write strobe.
- addr  in  2  register select: 0 ENABLE, 1 PEND, 2 INSERV, 3 BASE.
- wdata  in  32  write data.
- rdata  out  32  combinational read of the addressed register, zero-extended.
- intr  out  1  interrupt request to the CPU; registered output.
- inta  in  1  CPU acknowledge, a 1-cycle pulse.
- vector  out  32  handler address; registered, holds its value until the next acknowledge.

Behaviour:
- Reset (clrn=0, asynchronous):
  - ENABLE, PEND, INSERV, BASE, the irq edge history, intr and vector all clear to 0.
  - State goes to IDLE. Reset may arrive in any state and aborts any handshake in progress.
- Edge capture: irq_q holds last cycle's irq. A cycle with irq[i]=1 and irq_q[i]=0 sets PEND[i] at that clock edge.
- Register writes:
  - ENABLE: read/write.
  - PEND: write-1-to-clear.
  - INSERV: any write is an EOI and clears the lowest-index set bit (the highest-priority in-service source).
  - BASE: read/write; bits [1:0] are forced to 0.
- Candidate logic:
  - cand = PEND & ENABLE.
  - win = lowest-index set bit of cand.
  - top = lowest-index set bit of INSERV, or NSRC if INSERV=0.
  - eligible = (cand != 0) and (win < top).
- FSM states:
  - IDLE: intr=0. If eligible, go to REQ; intr becomes 1 at the same edge.
  - REQ: intr=1 and is held until inta is sampled high. While in REQ, win is re-evaluated every cycle, so a higher-priority arrival displaces the earlier winner.
  - On the edge where inta=1 in REQ:
    - If eligible: vector <= BASE + win*VSTRIDE, PEND[win] cleared, INSERV[win] set.
    - Otherwise the acknowledge is spurious: vector <= BASE + NSRC*VSTRIDE and PEND/INSERV are unchanged.
    - In both cases go to IDLE with intr=0 after that edge.
  - inta in IDLE is ignored.
- Latency:
  - A rising edge of irq sampled at clock edge k sets PEND at edge k.
  - intr is high after edge k+1.
  - intr is low and vector valid after the acknowledge edge.
  - The minimum gap between successive requests is one IDLE cycle.
- Simultaneous events:
  - Edge set wins over W1C clear and over acknowledge clear on the same bit.
  - EOI and acknowledge in the same cycle: EOI clears first, then the acknowledge sets its bit.
  - A write to ENABLE takes effect for the next cycle's eligibility.
- Arithmetic: vector is computed modulo 2^32; wrap-around is not flagged.

Decomposition:
- Package pic_pkg holds:
  - state enum {IDLE, REQ};
  - address constants A_ENABLE=0, A_PEND=1, A_INSERV=2, A_BASE=3;
  - default VSTRIDE.
- Sub-module pic_prio_enc: parameterised lowest-index-first encoder with outputs valid and idx. It is instantiated twice, once for cand and once for INSERV.

Test Plan (NSRC=8, VSTRIDE=4, BASE=0x100):
1. Reset: hold clrn=0, then release -> intr=0, vector=0; rdata=0 for all four addresses.
2. Single request: write ENABLE=0xFF, BASE=0x100, then pulse irq[3] -> PEND=0x08 and intr=1 one cycle later. A 1-cycle inta -> vector=0x10C, INSERV=0x08, PEND=0, intr=0 on the next cycle.
3. Nesting: with INSERV=0x08, raise irq[5] -> PEND=0x20, intr stays 0.
   - Raise irq[1] -> intr=1; inta gives vector=0x104 and INSERV=0x0A.
   - EOI -> INSERV=0x08, intr stays 0. A second EOI -> INSERV=0; intr rises and inta gives vector=0x114.
4. Priority: raise irq[2] and irq[6] in the same cycle -> first acknowledge gives vector=0x108. After EOI, the second acknowledge gives vector=0x118.
5. Spurious acknowledge: while in REQ for source 4, write ENABLE=0, then inta -> vector=0x120, INSERV unchanged, PEND=0x10 retained, intr=0.
6. Reset mid-handshake: drive clrn=0 while intr=1 -> intr=0 immediately without a clock edge; after release all registers read 0 and a stray inta has no effect.

Source files
------------

// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_pkg
// Purpose  : Shared types and constants for the pic_arbiter interrupt
//            controller: FSM state encoding, register addresses and the
//            default vector stride.
// Revision : 1.0 - initial release
// ============================================================================
package pic_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [1:0] A_ENABLE = 2'd0;
  localparam logic [1:0] A_PEND   = 2'd1;
  localparam logic [1:0] A_INSERV = 2'd2;
  localparam logic [1:0] A_BASE   = 2'd3;

  localparam int DEF_VSTRIDE = 4;

endpackage : pic_pkg
`default_nettype wire

// File: rtl/pic_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : pic_prio_enc
// Purpose  : Lowest-index-first priority encoder.
// Ports    : req   - request vector, bit 0 has the highest priority
//            valid - at least one request bit is set
//            idx   - index of the lowest set bit (0 when valid=0)
// Revision : 1.0 - initial release
// ============================================================================
module pic_prio_enc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scanning from the top down lets the lowest set bit be the last writer.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule : pic_prio_enc
`default_nettype wire

// File: rtl/pic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pic_arbiter
// Purpose  : Programmable interrupt controller. Captures rising edges of
//            NSRC sources into PEND, masks with ENABLE, arbitrates by fixed
//            priority against the in-service set (INSERV) and drives a single
//            intr/inta handshake, returning a vector address on acknowledge.
// Ports    : clk    - system clock (rising edge)
//            clrn   - asynchronous active-low reset
//            irq    - level source requests, rising edge raises a request
//            we     - register write strobe
//            addr   - register select (ENABLE, PEND, INSERV, BASE)
//            wdata  - register write data
//            rdata  - combinational read data, zero-extended
//            intr   - registered interrupt request to the CPU
//            inta   - one-cycle CPU acknowledge
//            vector - registered handler address, held between acknowledges
// Revision : 1.0 - initial release
// ============================================================================
module pic_arbiter
  import pic_pkg::*;
#(
  parameter int NSRC    = 8,
  parameter int VSTRIDE = DEF_VSTRIDE
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [NSRC-1:0] irq,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            intr,
  input  logic            inta,
  output logic [31:0]     vector
);

  localparam int IW = $clog2(NSRC);
  localparam int TW = $clog2(NSRC + 1);

  state_t          state_q, state_d;
  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] inserv_q, inserv_d;
  logic [31:0]     base_q, base_d;
  logic [31:0]     vector_q, vector_d;
  logic            intr_q, intr_d;

  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] rise;
  logic            win_valid, ins_valid;
  logic [IW-1:0]   win_idx, ins_idx;
  logic [TW-1:0]   win_ext, top_ext;
  logic            eligible;

  assign cand = pend_q & enable_q;
  assign rise = irq & ~irq_q;

  pic_prio_enc #(.N(NSRC), .IW(IW)) u_win_enc (
    .req   (cand),
    .valid (win_valid),
    .idx   (win_idx)
  );

  pic_prio_enc #(.N(NSRC), .IW(IW)) u_ins_enc (
    .req   (inserv_q),
    .valid (ins_valid),
    .idx   (ins_idx)
  );

  // An empty in-service set behaves as "top = NSRC", which every valid
  // winner beats; hence the extra bit in the compare width.
  assign win_ext  = TW'(win_idx);
  assign top_ext  = ins_valid ? TW'(ins_idx) : TW'(NSRC);
  assign eligible = win_valid && (win_ext < top_ext);

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    pend_d   = pend_q;
    inserv_d = inserv_q;
    base_d   = base_q;
    vector_d = vector_q;
    intr_d   = intr_q;

    if (we) begin
      unique case (addr)
        A_ENABLE: enable_d = wdata[NSRC-1:0];
        A_PEND:   pend_d   = pend_q & ~wdata[NSRC-1:0];
        A_INSERV: if (ins_valid) inserv_d[ins_idx] = 1'b0;
        A_BASE:   base_d   = {wdata[31:2], 2'b00};
        default:  ;
      endcase
    end

    // EOI has already been applied to inserv_d above, so an acknowledge in
    // the same cycle sets its bit on top of the cleared value.
    unique case (state_q)
      IDLE: begin
        intr_d = 1'b0;
        if (eligible) begin
          state_d = REQ;
          intr_d  = 1'b1;
        end
      end
      REQ: begin
        intr_d = 1'b1;
        if (inta) begin
          state_d = IDLE;
          intr_d  = 1'b0;
          if (eligible) begin
            vector_d          = base_q + 32'(win_idx) * 32'(VSTRIDE);
            pend_d[win_idx]   = 1'b0;
            inserv_d[win_idx] = 1'b1;
          end else begin
            vector_d = base_q + 32'(NSRC * VSTRIDE);
          end
        end
      end
      default: begin
        state_d = IDLE;
        intr_d  = 1'b0;
      end
    endcase

    // A fresh edge always survives a same-cycle clear.
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      irq_q    <= '0;
      enable_q <= '0;
      pend_q   <= '0;
      inserv_q <= '0;
      base_q   <= '0;
      vector_q <= '0;
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq;
      enable_q <= enable_d;
      pend_q   <= pend_d;
      inserv_q <= inserv_d;
      base_q   <= base_d;
      vector_q <= vector_d;
      intr_q   <= intr_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (addr)
      A_ENABLE: rdata = 32'(enable_q);
      A_PEND:   rdata = 32'(pend_q);
      A_INSERV: rdata = 32'(inserv_q);
      A_BASE:   rdata = base_q;
      default:  rdata = '0;
    endcase
  end

  assign intr   = intr_q;
  assign vector = vector_q;

endmodule : pic_arbiter
`default_nettype wire

// File: tb/tb_pic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_arbiter
// Purpose  : Directed self-checking bench for pic_arbiter (NSRC=8,
//            VSTRIDE=4, BASE=0x100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_arbiter;

  logic        clk;
  logic        clrn;
  logic [7:0]  irq;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        intr;
  logic        inta;
  logic [31:0] vector;

  int n_checks;
  int n_pass;

  pic_arbiter #(.NSRC(8), .VSTRIDE(4)) dut (
    .clk    (clk),
    .clrn   (clrn),
    .irq    (irq),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .intr   (intr),
    .inta   (inta),
    .vector (vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic ack();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq = m;
    tick();
    irq = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clrn  = 1'b0;
    irq   = '0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    inta  = 1'b0;

    // 1. reset
    repeat (3) tick();
    clrn = 1'b1;
    tick();
    check("rst_intr", {31'd0, intr}, 32'd0);
    check("rst_vector", vector, 32'd0);
    rd_check("rst_enable", 2'd0, 32'd0);
    rd_check("rst_pend",   2'd1, 32'd0);
    rd_check("rst_inserv", 2'd2, 32'd0);
    rd_check("rst_base",   2'd3, 32'd0);

    // 2. single request
    wr(2'd0, 32'h0000_00FF);
    wr(2'd3, 32'h0000_0103);          // low bits must be dropped
    rd_check("base_mask", 2'd3, 32'h100);
    pulse_irq(8'h08);
    rd_check("s_pend", 2'd1, 32'h08);
    check("s_intr_lat0", {31'd0, intr}, 32'd0);
    tick();
    check("s_intr_up", {31'd0, intr}, 32'd1);
    ack();
    check("s_vector", vector, 32'h10C);
    check("s_intr_dn", {31'd0, intr}, 32'd0);
    rd_check("s_inserv", 2'd2, 32'h08);
    rd_check("s_pend0", 2'd1, 32'h00);

    // 3. nesting
    pulse_irq(8'h20);
    rd_check("n_pend5", 2'd1, 32'h20);
    tick();
    check("n_masked", {31'd0, intr}, 32'd0);
    pulse_irq(8'h02);
    tick();
    check("n_intr1", {31'd0, intr}, 32'd1);
    ack();
    check("n_vec1", vector, 32'h104);
    rd_check("n_inserv0a", 2'd2, 32'h0A);
    wr(2'd2, 32'd0);
    rd_check("n_eoi1", 2'd2, 32'h08);
    tick();
    check("n_still0", {31'd0, intr}, 32'd0);
    wr(2'd2, 32'd0);
    rd_check("n_eoi2", 2'd2, 32'h00);
    tick();
    check("n_intr5", {31'd0, intr}, 32'd1);
    ack();
    check("n_vec5", vector, 32'h114);
    wr(2'd2, 32'd0);

    // 4. priority
    pulse_irq(8'h44);
    tick();
    check("p_intr", {31'd0, intr}, 32'd1);
    ack();
    check("p_vec2", vector, 32'h108);
    rd_check("p_pend6", 2'd1, 32'h40);
    wr(2'd2, 32'd0);
    tick();
    check("p_intr6", {31'd0, intr}, 32'd1);
    ack();
    check("p_vec6", vector, 32'h118);
    rd_check("p_inserv6", 2'd2, 32'h40);
    wr(2'd2, 32'd0);

    // 5. spurious acknowledge
    pulse_irq(8'h10);
    tick();
    check("sp_intr", {31'd0, intr}, 32'd1);
    wr(2'd0, 32'd0);
    check("sp_held", {31'd0, intr}, 32'd1);
    ack();
    check("sp_vec", vector, 32'h120);
    check("sp_intr_dn", {31'd0, intr}, 32'd0);
    rd_check("sp_inserv", 2'd2, 32'h00);
    rd_check("sp_pend", 2'd1, 32'h10);

    // 6. reset mid-handshake
    wr(2'd0, 32'h0000_00FF);
    tick();
    check("r_intr_up", {31'd0, intr}, 32'd1);
    clrn = 1'b0;
    #1;
    check("r_async_intr", {31'd0, intr}, 32'd0);
    check("r_async_vec", vector, 32'd0);
    #2;
    clrn = 1'b1;
    rd_check("r_enable", 2'd0, 32'd0);
    rd_check("r_pend",   2'd1, 32'd0);
    rd_check("r_inserv", 2'd2, 32'd0);
    rd_check("r_base",   2'd3, 32'd0);
    tick();
    ack();
    check("r_stray_intr", {31'd0, intr}, 32'd0);
    check("r_stray_vec", vector, 32'd0);
    rd_check("r_stray_ins", 2'd2, 32'd0);

    // Edge set beats a same-cycle W1C on the same bit.
    irq = 8'h80;
    wr(2'd1, 32'h0000_00FF);
    irq = '0;
    rd_check("e_edge_wins", 2'd1, 32'h80);
    wr(2'd1, 32'h0000_0080);
    rd_check("e_w1c", 2'd1, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pic_arbiter
`default_nettype wire
